mvm_sequencer: RTL and testbench
================================

// Module: mvm_sequencer
// PURPOSE
//  Time-multiplexed matrix-vector engine controller: computes Y[i] = sum_j W[i][j]*x[j] + B[i]
//  with one shared mac_unit instead of an M x N MAC array. Walks row/column indices, drives
//  synchronous-read address ports of the W, x and B memories, and accumulates products.
//  Emits one result per row over a valid/ready stream. Sits between the layer controller
//  (start/done) and the activation stage (Y stream).
// PARAMETERS
//  N   2   input vector length (columns), >=1
//  M   2   output vector length (rows), >=1
//  Derived: AW_W = max(1,$clog2(M*N)), AW_X = max(1,$clog2(N)), AW_R = max(1,$clog2(M))
// PORTS
//  clk      in   1     clock, rising edge
//  rst_n    in   1     asynchronous active-low reset
//  start    in   1     1-cycle request to begin a full M-row pass; ignored unless IDLE
//  abort    in   1     synchronous cancel; return to IDLE, no done pulse
//  busy     out  1     high whenever state != IDLE
//  done     out  1     1-cycle pulse after the last row's handshake
//  rd_en    out  1     read strobe to the W/x memories; data returns next cycle
//  w_addr   out  AW_W  W address = row*N + col
//  x_addr   out  AW_X  x address = col
//  w_data   in   8     W read data, valid 1 cycle after rd_en
//  x_data   in   8     x read data, valid 1 cycle after rd_en
//  b_addr   out  AW_R  bias address = current row, held for the whole row
//  b_data   in   16    bias read data, sampled in DRAIN
//  y_valid  out  1     result valid
//  y_ready  in   1     downstream accepts the result
//  y_data   out  16    Y[row]
//  y_row    out  AW_R  row index of y_data
// BEHAVIOUR
//  Reset: state=IDLE; row, col, acc=0; busy, done, rd_en, y_valid=0; y_data=0; y_row=0;
//   all addresses 0.
//  FSM IDLE -> RUN (start) -> DRAIN -> OUT -> RUN (next row) | DONE -> IDLE.
//  IDLE: start=1 -> RUN next cycle; col=0, acc=0.
//  RUN: rd_en=1 each cycle, addresses from (row,col), col++; after col==N-1 is issued -> DRAIN.
//   N=1 gives one RUN cycle.
//  Accumulate: dvld = rd_en delayed 1 cycle; when dvld, acc <= acc + w_data*x_data via mac_unit.
//  DRAIN: absorbs the last product; y_data <= acc + w_data*x_data + b_data -> OUT.
//  OUT: y_valid=1 and y_data/y_row held stable until y_ready.
//   On handshake: if row==M-1 -> DONE, else row++, col=0, acc=0 -> RUN.
//  DONE: done=1 for exactly one cycle -> IDLE; row=0.
//  Timing, y_ready tied 1, start at cycle 0: row r first RUN cycle = 1 + r*(N+2).
//   Row r y_valid cycle = (r+1)*(N+2). done at M*(N+2)+1; busy cycles 1..M*(N+2)+1.
//  Arithmetic: 8x8 unsigned product, 16-bit accumulate and bias add, all modulo 2^16
//   (wrap, no saturation, no overflow flag).
//  start while busy: ignored, no restart.
//  abort (any non-IDLE state): IDLE next cycle; y_valid, rd_en drop; acc, row, col cleared;
//   no done. abort has priority over start, over y_ready and over every state transition.
//  rst_n low mid-operation: immediate return to reset values; in-flight memory reads discarded.
//  y_ready while y_valid=0: no effect.
//  Bias memory must be stable for the row duration; b_data is sampled only in DRAIN.
// STRUCTURE
//  Shared package mvm_pkg: FSM state encoding (IDLE, RUN, DRAIN, OUT, DONE), DATA_W=8,
//   ACC_W=16, and the address-width helper function.
//  One sub-module: the existing mac_unit (a,b,c,out), one instance; c=acc, out feeds acc.
//  Counters and FSM stay in this module; no other hierarchy.
// TESTING
//  1 N=2,M=2, W=[[1,2],[3,4]], x=[5,6], B=[10,20], y_ready=1, start@0
//    -> Y0=27 (y_row 0) at cycle 4, Y1=59 (y_row 1) at cycle 8, done at cycle 9.
//  2 Same data, y_ready low 3 cycles in each OUT -> y_data/y_row stable while stalled;
//    each row resumes 1 cycle after its handshake; done at cycle 15.
//  3 N=2,M=1, W=[255,255], x=[255,255], B=[0]
//    -> Y0 = 130050 mod 65536 = 64514 (wrap, no flag).
//  4 start pulsed at cycle 3 of a running pass -> ignored; results and done timing same as test 1.
//  5 abort in row 1 RUN -> IDLE next cycle, no done, no further y_valid;
//    fresh start then gives 27/59 again.
//  6 rst_n low during DRAIN -> all outputs 0 at once; after release, start gives correct results.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector sequencer: FSM encoding, datapath
// widths and the address-width helper.
package mvm_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } state_t;

  // Address width for a memory of 'depth' words, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mvm_sequencer_if.sv
// Memory read ports and result stream of the matrix-vector sequencer.
// master = sequencer side, slave = memories plus activation stage.
interface mvm_sequencer_if
  import mvm_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2
);

  localparam int AW_W = addr_w(M * N);
  localparam int AW_X = addr_w(N);
  localparam int AW_R = addr_w(M);

  logic              rd_en;
  logic [AW_W-1:0]   w_addr;
  logic [AW_X-1:0]   x_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] x_data;
  logic [AW_R-1:0]   b_addr;
  logic [ACC_W-1:0]  b_data;
  logic              y_valid;
  logic              y_ready;
  logic [ACC_W-1:0]  y_data;
  logic [AW_R-1:0]   y_row;

  modport master (
    output rd_en, w_addr, x_addr, b_addr, y_valid, y_data, y_row,
    input  w_data, x_data, b_data, y_ready
  );

  modport slave (
    input  rd_en, w_addr, x_addr, b_addr, y_valid, y_data, y_row,
    output w_data, x_data, b_data, y_ready
  );

endinterface

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: out = c + a*b, unsigned, wrapping at ACC_W bits.
module mac_unit
  import mvm_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  c,
  output logic [ACC_W-1:0]  out
);

  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a) * ACC_W'(b);
  assign out  = c + prod;

endmodule

// File: rtl/mvm_sequencer.sv
// Time-multiplexed matrix-vector engine controller: Y[i] = sum_j W[i][j]*x[j] + B[i]
// computed row by row through a single shared mac_unit.
module mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  mvm_sequencer_if.master bus
);

  localparam int AW_W = addr_w(M * N);
  localparam int AW_X = addr_w(N);
  localparam int AW_R = addr_w(M);
  localparam logic [AW_X-1:0] COL_LAST = AW_X'(N - 1);
  localparam logic [AW_R-1:0] ROW_LAST = AW_R'(M - 1);

  state_t            state;
  logic [AW_R-1:0]   row;
  logic [AW_X-1:0]   col;
  logic [AW_W-1:0]   w_addr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  mac_out;
  logic [ACC_W-1:0]  y_data;
  logic [AW_R-1:0]   y_row;
  logic              rd_en;
  logic              dvld;
  logic              y_valid;

  mac_unit u_mac (
    .a   (bus.w_data),
    .b   (bus.x_data),
    .c   (acc),
    .out (mac_out)
  );

  // Rows are walked in order, so the W address simply keeps counting across rows.
  assign bus.rd_en   = rd_en;
  assign bus.w_addr  = w_addr;
  assign bus.x_addr  = col;
  assign bus.b_addr  = row;
  assign bus.y_valid = y_valid;
  assign bus.y_data  = y_data;
  assign bus.y_row   = y_row;

  // abort outranks every transition; dvld is cleared so an in-flight read is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      w_addr  <= '0;
      acc     <= '0;
      dvld    <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_row   <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      w_addr  <= '0;
      acc     <= '0;
      dvld    <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      dvld <= rd_en;
      done <= 1'b0;
      if (dvld) begin
        acc <= mac_out;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            row    <= '0;
            col    <= '0;
            w_addr <= '0;
            acc    <= '0;
            rd_en  <= 1'b1;
            busy   <= 1'b1;
          end
        end

        ST_RUN: begin
          if (col == COL_LAST) begin
            state <= ST_DRAIN;
            rd_en <= 1'b0;
          end else begin
            col    <= col + AW_X'(1);
            w_addr <= w_addr + AW_W'(1);
          end
        end

        ST_DRAIN: begin
          y_data  <= mac_out + bus.b_data;
          y_row   <= row;
          y_valid <= 1'b1;
          state   <= ST_OUT;
        end

        ST_OUT: begin
          if (bus.y_ready) begin
            y_valid <= 1'b0;
            if (row == ROW_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state  <= ST_RUN;
              row    <= row + AW_R'(1);
              col    <= '0;
              w_addr <= w_addr + AW_W'(1);
              acc    <= '0;
              rd_en  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          row    <= '0;
          col    <= '0;
          w_addr <= '0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer (N=2, M=2): table-driven passes with a
// result scoreboard, plus stall, restart, abort and mid-pass reset sequences.
module tb_mvm_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  mvm_sequencer_if #(.N(2), .M(2)) bus ();

  mvm_sequencer #(.N(2), .M(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  w0, w1, w2, w3;
    logic [7:0]  x0, x1;
    logic [15:0] b0, b1;
    logic [15:0] y0, y1;
  } vec_t;

  typedef struct {
    int row;
    int data;
    int cyc;
  } exp_t;

  vec_t        vecs[5];
  exp_t        sbq[$];
  logic [7:0]  wmem[4];
  logic [7:0]  xmem[2];
  logic [15:0] bmem[2];
  int          cyc;
  int          t0;
  int          vectors;
  int          miscompares;
  bit          seen_first;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read W/x memories; bias memory is read combinationally.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.w_data <= wmem[bus.w_addr];
      bus.x_data <= xmem[bus.x_addr];
    end
  end
  assign bus.b_data = bmem[bus.b_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every valid cycle is checked against the scoreboard head; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n && bus.y_valid) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_y_valid: got y_valid=1 (y_data=%0d), expected no result", bus.y_data);
      end else begin
        checkOutput("y_data", 32'(bus.y_data), 32'(sbq[0].data));
        checkOutput("y_row", 32'(bus.y_row), 32'(sbq[0].row));
        if (!seen_first) begin
          checkOutput("y_valid_cycle", 32'(cyc - t0), 32'(sbq[0].cyc));
          seen_first = 1'b1;
        end
        if (bus.y_ready) begin
          void'(sbq.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic setVec(input int i,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3,
                        input logic [7:0] x0, input logic [7:0] x1,
                        input logic [15:0] b0, input logic [15:0] b1,
                        input logic [15:0] y0, input logic [15:0] y1);
    vecs[i] = '{w0:w0, w1:w1, w2:w2, w3:w3, x0:x0, x1:x1, b0:b0, b1:b1, y0:y0, y1:y1};
  endtask

  task automatic loadVec(input int vi);
    wmem[0] = vecs[vi].w0;
    wmem[1] = vecs[vi].w1;
    wmem[2] = vecs[vi].w2;
    wmem[3] = vecs[vi].w3;
    xmem[0] = vecs[vi].x0;
    xmem[1] = vecs[vi].x1;
    bmem[0] = vecs[vi].b0;
    bmem[1] = vecs[vi].b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    checkOutput({tag, "_y_valid"}, 32'(bus.y_valid), 0);
    checkOutput({tag, "_y_data"}, 32'(bus.y_data), 0);
    checkOutput({tag, "_y_row"}, 32'(bus.y_row), 0);
    checkOutput({tag, "_w_addr"}, 32'(bus.w_addr), 0);
    checkOutput({tag, "_x_addr"}, 32'(bus.x_addr), 0);
    checkOutput({tag, "_b_addr"}, 32'(bus.b_addr), 0);
  endtask

  // One full pass: optional 3-cycle stall per result, optional stray start pulse.
  task automatic applyStimulus(input int vi, input bit stall, input int restart_at);
    int done_cyc;
    int done_cnt;
    int rd_cnt;
    int stall_cnt;
    loadVec(vi);
    sbq.push_back('{row:0, data:int'(vecs[vi].y0), cyc:4});
    sbq.push_back('{row:1, data:int'(vecs[vi].y1), cyc:(stall ? 11 : 8)});
    done_cyc  = -1;
    done_cnt  = 0;
    rd_cnt    = 0;
    stall_cnt = 0;
    @(posedge clk);
    #1;
    t0      = cyc;
    start   = 1'b1;
    bus.y_ready = !stall;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      start = (k == restart_at);
      if (k == 1) checkOutput("busy_in_run", 32'(busy), 1);
      if (bus.rd_en) rd_cnt++;
      if (done) begin
        if (done_cyc < 0) done_cyc = k;
        done_cnt++;
      end
      if (stall) begin
        if (bus.y_valid) begin
          bus.y_ready = (stall_cnt == 3);
          stall_cnt++;
        end else begin
          bus.y_ready = 1'b0;
          stall_cnt   = 0;
        end
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    start       = 1'b0;
    bus.y_ready = 1'b1;
    checkOutput("done_cycle", 32'(done_cyc), stall ? 32'd15 : 32'd9);
    checkOutput("done_pulses", 32'(done_cnt), 1);
    checkOutput("rd_en_cycles", 32'(rd_cnt), 4);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("results_pending", 32'(sbq.size()), 0);
    sbq.delete();
    seen_first = 1'b0;
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    t0          = 0;
    seen_first  = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    bus.y_ready = 1'b1;

    setVec(0,   1,   2,   3,   4,   5,   6,  16'd10,    16'd20,    16'd27,    16'd59);
    setVec(1, 255, 255, 200, 255, 255, 255,  16'd0,     16'd65535, 16'd64514, 16'd50488);
    setVec(2,   0,   0,   0,   0,   7,   9,  16'd100,   16'd200,   16'd100,   16'd200);
    setVec(3,  10,   0,   0,  10,   3,   4,  16'd1,     16'd2,     16'd31,    16'd42);
    setVec(4,   2,   3,   5,   7,  11,  13,  16'd0,     16'd1000,  16'd61,    16'd1146);
    loadVec(0);

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] table-driven passes, y_ready held high");
    for (int vi = 0; vi < 5; vi++) begin
      applyStimulus(vi, 1'b0, -1);
    end

    $display("[TB] back-pressure: y_ready low for 3 cycles per result");
    applyStimulus(0, 1'b1, -1);

    $display("[TB] stray start pulse during a pass");
    applyStimulus(0, 1'b0, 3);

    $display("[TB] abort in row 1 RUN");
    loadVec(0);
    sbq.push_back('{row:0, data:27, cyc:4});
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 5) begin
        checkOutput("abort_pre_rd_en", 32'(bus.rd_en), 1);
        checkOutput("abort_pre_b_addr", 32'(bus.b_addr), 1);
        abort = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rd_en", 32'(bus.rd_en), 0);
    checkOutput("abort_y_valid", 32'(bus.y_valid), 0);
    checkOutput("abort_b_addr", 32'(bus.b_addr), 0);
    checkOutput("abort_w_addr", 32'(bus.w_addr), 0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_done_pulses", 32'(done_seen), 0);
    checkOutput("abort_results_pending", 32'(sbq.size()), 0);
    sbq.delete();
    seen_first = 1'b0;
    applyStimulus(0, 1'b0, -1);

    $display("[TB] reset asserted in row 1 DRAIN");
    loadVec(0);
    sbq.push_back('{row:0, data:27, cyc:4});
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checkOutput("pre_reset_y_data", 32'(bus.y_data), 27);
    checkOutput("pre_reset_w_addr", 32'(bus.w_addr), 3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    sbq.delete();
    seen_first = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    applyStimulus(1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
